// File: rtl/tag_directory_controller_pkg.sv
// Shared types for the tag directory controller: FSM state encoding and the
// requester-index width helper.
package tag_directory_controller_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLookup,
    StStall,
    StRespond
  } state_e;

  // A single requester still needs a 1-bit index field.
  function automatic int unsigned requester_width(input int unsigned requesters);
    return (requesters > 1) ? $clog2(requesters) : 1;
  endfunction

endpackage

// File: rtl/tag_directory_controller_round_robin_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from the requester after the
// last grant; the pointer moves only when the grant is taken.
module round_robin_arbiter
  import tag_directory_controller_pkg::*;
#(
  parameter int unsigned REQUESTERS = 2,
  localparam int unsigned REQ_WIDTH = requester_width(REQUESTERS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REQUESTERS-1:0] request,
  input  logic                  advance,
  output logic [REQUESTERS-1:0] grant,
  output logic [REQ_WIDTH-1:0]  grant_index
);

  logic [REQ_WIDTH-1:0] pointer_q;
  int unsigned          candidate;

  // Scan offsets from farthest to nearest so the nearest asserted requester wins.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    candidate   = 0;
    for (int unsigned k = REQUESTERS; k > 0; k--) begin
      candidate = (32'(pointer_q) + k - 1) % REQUESTERS;
      if (request[candidate]) begin
        grant            = '0;
        grant[candidate] = 1'b1;
        grant_index      = REQ_WIDTH'(candidate);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pointer_q <= '0;
    end else if (advance) begin
      pointer_q <= REQ_WIDTH'((32'(grant_index) + 1) % REQUESTERS);
    end
  end

endmodule

// File: rtl/tag_directory_controller.sv
// Arbitrated lookup-or-allocate front end for a tag directory with per-entry reference counts.
// Optional statistics counters: define TAG_DIRECTORY_CONTROLLER_STATISTICS_EN.
module tag_directory_controller
  import tag_directory_controller_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned REQUESTERS  = 2,
  parameter int unsigned COUNT_WIDTH = 4,
  localparam int unsigned INDEX_WIDTH = $clog2(DEPTH),
  localparam int unsigned REQ_WIDTH   = requester_width(REQUESTERS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [REQUESTERS-1:0]        request_valid,
  input  logic [REQUESTERS*WIDTH-1:0]  request_tag,
  output logic [REQUESTERS-1:0]        request_ready,
  output logic                         response_valid,
  input  logic                         response_ready,
  output logic [REQ_WIDTH-1:0]         response_requester,
  output logic [INDEX_WIDTH-1:0]       response_index,
  output logic                         response_hit,
  input  logic                         release_valid,
  input  logic [INDEX_WIDTH-1:0]       release_index,
  input  logic                         dir_full,
  input  logic                         dir_empty,
  output logic                         dir_allocate_enable,
  output logic [WIDTH-1:0]             dir_allocate_tag,
  input  logic [INDEX_WIDTH-1:0]       dir_allocate_index,
  output logic [WIDTH-1:0]             dir_search_tag,
  input  logic [INDEX_WIDTH-1:0]       dir_search_index,
  input  logic                         dir_search_hit,
  output logic                         dir_evict_enable,
  output logic [INDEX_WIDTH-1:0]       dir_evict_index
`ifdef TAG_DIRECTORY_CONTROLLER_STATISTICS_EN
  ,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count,
  output logic [31:0]                  stall_count
`endif
);

  localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

  state_e                 state_q;
  logic [WIDTH-1:0]       tag_q;
  logic [REQ_WIDTH-1:0]   requester_q;
  logic [COUNT_WIDTH-1:0] count_q [DEPTH];
  logic [COUNT_WIDTH-1:0] count_d [DEPTH];
  logic [REQUESTERS-1:0]  grant;
  logic [REQ_WIDTH-1:0]   grant_index;
  logic [WIDTH-1:0]       granted_tag;
  logic                   accept, evaluating, hit_ok, allocate, release_ok, release_hit_same;

  round_robin_arbiter #(
    .REQUESTERS (REQUESTERS)
  ) u_arbiter (
    .clock       (clock),
    .reset       (reset),
    .request     (request_valid),
    .advance     (accept),
    .grant       (grant),
    .grant_index (grant_index)
  );

  always_comb begin
    granted_tag = '0;
    for (int unsigned r = 0; r < REQUESTERS; r++) begin
      if (grant[r]) granted_tag = request_tag[r*WIDTH +: WIDTH];
    end
  end

  assign request_ready = (state_q == StIdle) ? grant : '0;
  assign accept        = |(request_valid & request_ready);
  assign evaluating    = (state_q == StLookup) || (state_q == StStall);

  // A hit on a saturated entry stalls rather than creating a duplicate.
  assign hit_ok   = evaluating && dir_search_hit && !dir_empty &&
                    (count_q[dir_search_index] != CountMax);
  assign allocate = evaluating && !dir_search_hit && !dir_full && !reset;

  assign dir_search_tag      = evaluating ? tag_q : '0;
  assign dir_allocate_enable = allocate;
  assign dir_allocate_tag    = allocate ? tag_q : '0;

  assign release_ok       = release_valid && !reset && (count_q[release_index] != '0);
  assign release_hit_same = hit_ok && (dir_search_index == release_index);
  assign dir_evict_enable = release_ok && !release_hit_same &&
                            (count_q[release_index] == COUNT_WIDTH'(1));
  assign dir_evict_index  = dir_evict_enable ? release_index : '0;

  // Allocated slots are free (count 0), so a release there is ignored; hit and release cancel.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count_d[i] = count_q[i];
      if (allocate && dir_allocate_index == INDEX_WIDTH'(i)) count_d[i] = COUNT_WIDTH'(1);
      if (hit_ok && dir_search_index == INDEX_WIDTH'(i)) count_d[i] = count_d[i] + COUNT_WIDTH'(1);
      if (release_ok && release_index == INDEX_WIDTH'(i)) begin
        count_d[i] = count_d[i] - COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q            <= StIdle;
      tag_q              <= '0;
      requester_q        <= '0;
      response_valid     <= 1'b0;
      response_requester <= '0;
      response_index     <= '0;
      response_hit       <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) count_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) count_q[i] <= count_d[i];
      case (state_q)
        StIdle: begin
          if (accept) begin
            tag_q       <= granted_tag;
            requester_q <= grant_index;
            state_q     <= StLookup;
          end
        end
        StLookup, StStall: begin
          if (hit_ok) begin
            response_valid     <= 1'b1;
            response_requester <= requester_q;
            response_index     <= dir_search_index;
            response_hit       <= 1'b1;
            state_q            <= StRespond;
          end else if (allocate) begin
            response_valid     <= 1'b1;
            response_requester <= requester_q;
            response_index     <= dir_allocate_index;
            response_hit       <= 1'b0;
            state_q            <= StRespond;
          end else begin
            state_q <= StStall;
          end
        end
        StRespond: begin
          if (response_ready) begin
            response_valid <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef TAG_DIRECTORY_CONTROLLER_STATISTICS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count   <= '0;
      miss_count  <= '0;
      stall_count <= '0;
    end else begin
      if (hit_ok && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (allocate && miss_count != '1) miss_count <= miss_count + 32'd1;
      if (state_q == StStall && stall_count != '1) stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tag_directory_controller.sv
// Bench for tag_directory_controller with a behavioural tag directory alongside it.
module tb_tag_directory_controller;

  logic        clock = 1'b0;
  logic        reset, dir_reset;
  logic [1:0]  request_valid;
  logic [15:0] request_tag;
  logic [1:0]  request_ready;
  logic        response_valid, response_ready;
  logic        response_requester;
  logic [3:0]  response_index;
  logic        response_hit;
  logic        release_valid;
  logic [3:0]  release_index;
  logic        dir_full, dir_empty;
  logic        dir_allocate_enable;
  logic [7:0]  dir_allocate_tag;
  logic [3:0]  dir_allocate_index;
  logic [7:0]  dir_search_tag;
  logic [3:0]  dir_search_index;
  logic        dir_search_hit;
  logic        dir_evict_enable;
  logic [3:0]  dir_evict_index;

  always #5 clock = ~clock;

  tag_directory_controller #(
    .WIDTH       (8),
    .DEPTH       (16),
    .REQUESTERS  (2),
    .COUNT_WIDTH (4)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .request_valid       (request_valid),
    .request_tag         (request_tag),
    .request_ready       (request_ready),
    .response_valid      (response_valid),
    .response_ready      (response_ready),
    .response_requester  (response_requester),
    .response_index      (response_index),
    .response_hit        (response_hit),
    .release_valid       (release_valid),
    .release_index       (release_index),
    .dir_full            (dir_full),
    .dir_empty           (dir_empty),
    .dir_allocate_enable (dir_allocate_enable),
    .dir_allocate_tag    (dir_allocate_tag),
    .dir_allocate_index  (dir_allocate_index),
    .dir_search_tag      (dir_search_tag),
    .dir_search_index    (dir_search_index),
    .dir_search_hit      (dir_search_hit),
    .dir_evict_enable    (dir_evict_enable),
    .dir_evict_index     (dir_evict_index)
  );

  // Behavioural directory: fully associative, allocates the lowest free slot.
  logic [15:0] dvalid;
  logic [7:0]  dtag [16];

  always_comb begin
    dir_search_hit     = 1'b0;
    dir_search_index   = '0;
    dir_allocate_index = '0;
    for (int i = 15; i >= 0; i--) begin
      if (dvalid[i] && dtag[i] == dir_search_tag) begin
        dir_search_hit   = 1'b1;
        dir_search_index = 4'(i);
      end
      if (!dvalid[i]) dir_allocate_index = 4'(i);
    end
  end
  assign dir_full  = &dvalid;
  assign dir_empty = ~|dvalid;

  always_ff @(posedge clock) begin
    if (dir_reset) begin
      dvalid <= '0;
    end else begin
      if (dir_allocate_enable) begin
        dvalid[dir_allocate_index] <= 1'b1;
        dtag[dir_allocate_index]   <= dir_allocate_tag;
      end
      if (dir_evict_enable) dvalid[dir_evict_index] <= 1'b0;
    end
  end

  typedef struct {
    logic       requester;
    logic [3:0] index;
    logic       hit;
  } exp_t;

  typedef struct {
    int         req;
    logic [7:0] tag;
    logic [3:0] index;
    logic       hit;
  } vec_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard: compare each accepted response against the oldest expectation.
  always @(negedge clock) begin
    if (!reset && response_valid && response_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_response: got index 0x%0h, expected no response", response_index);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_requester", 32'(response_requester), 32'(e.requester));
        check("resp_index", 32'(response_index), 32'(e.index));
        check("resp_hit", 32'(response_hit), 32'(e.hit));
      end
    end
  end

  // Waits on negedges until requester r is granted; leaves time just before the accept edge.
  task automatic wait_ready(input int r, output bit ok);
    int w;
    w  = 0;
    ok = 1'b0;
    while (!ok && w < 40) begin
      @(negedge clock);
      ok = request_ready[r];
      w++;
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got no grant for requester %0d, expected one", r);
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(posedge clock);
      w++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL response_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_request(input int r, input logic [7:0] tag, input logic [3:0] idx,
                            input logic hit);
    bit   ok;
    exp_t e;
    @(posedge clock); #1;
    request_valid[r]      = 1'b1;
    request_tag[r*8 +: 8] = tag;
    wait_ready(r, ok);
    if (ok) begin
      e.requester = 1'(r);
      e.index     = idx;
      e.hit       = hit;
      sb.push_back(e);
      @(posedge clock); #1;
      request_valid[r] = 1'b0;
      @(negedge clock);
      check("latency_lookup_quiet", 32'(response_valid), 32'd0);
      @(negedge clock);
      check("latency_valid", 32'(response_valid), 32'd1);
      drain();
    end else begin
      request_valid[r] = 1'b0;
    end
  endtask

  task automatic do_release(input logic [3:0] idx, input logic exp_evict);
    @(posedge clock); #1;
    release_valid = 1'b1;
    release_index = idx;
    @(negedge clock);
    check("evict_enable", 32'(dir_evict_enable), 32'(exp_evict));
    if (exp_evict) check("evict_index", 32'(dir_evict_index), 32'(idx));
    @(posedge clock); #1;
    release_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   n[2];
    int   idx_of[2];
    int   next_free;
    int   last;
    int   g;
    int   w;
    bit   ok;
    exp_t e;

    vecs[0] = '{req: 0, tag: 8'h3C, index: 4'd0, hit: 1'b0};
    vecs[1] = '{req: 1, tag: 8'h3C, index: 4'd0, hit: 1'b1};
    vecs[2] = '{req: 0, tag: 8'hA5, index: 4'd1, hit: 1'b0};
    vecs[3] = '{req: 1, tag: 8'h5A, index: 4'd2, hit: 1'b0};
    vecs[4] = '{req: 0, tag: 8'hA5, index: 4'd1, hit: 1'b1};

    reset          = 1'b1;
    dir_reset      = 1'b1;
    request_valid  = '0;
    request_tag    = '0;
    response_ready = 1'b1;
    release_valid  = 1'b0;
    release_index  = '0;
    repeat (3) @(posedge clock);
    #1;
    reset     = 1'b0;
    dir_reset = 1'b0;
    @(negedge clock);
    check("reset_request_ready", 32'(request_ready), 32'd0);
    check("reset_response_valid", 32'(response_valid), 32'd0);
    check("reset_search_tag", 32'(dir_search_tag), 32'd0);
    check("reset_allocate_enable", 32'(dir_allocate_enable), 32'd0);
    check("reset_evict_enable", 32'(dir_evict_enable), 32'd0);

    // Lookup-or-allocate table, then reference drop-off with eviction on the last release.
    for (int i = 0; i < 5; i++) do_request(vecs[i].req, vecs[i].tag, vecs[i].index, vecs[i].hit);
    do_release(4'd0, 1'b0);
    do_release(4'd0, 1'b1);
    do_release(4'd1, 1'b0);
    do_release(4'd1, 1'b1);
    do_release(4'd2, 1'b1);
    do_release(4'd2, 1'b0);
    @(negedge clock);
    check("empty_after_releases", 32'(dir_empty), 32'd1);

    // Both requesters always valid: grants must alternate.
    n         = '{0, 0};
    idx_of    = '{-1, -1};
    next_free = 0;
    last      = -1;
    @(posedge clock); #1;
    request_tag   = {8'h22, 8'h11};
    request_valid = 2'b11;
    for (int k = 0; k < 20; k++) begin
      w = 0;
      do begin
        @(negedge clock);
        w++;
      end while (request_ready == 2'b00 && w < 20);
      if (request_ready == 2'b00) begin
        check("rr_grant_timeout", 32'(request_ready), 32'd1);
        break;
      end
      check("rr_onehot", 32'($onehot(request_ready)), 32'd1);
      g = request_ready[1] ? 1 : 0;
      if (last >= 0) check("rr_alternate", 32'(g), 32'(1 - last));
      e.requester = 1'(g);
      if (idx_of[g] < 0) begin
        idx_of[g] = next_free;
        next_free++;
        e.hit = 1'b0;
      end else begin
        e.hit = 1'b1;
      end
      e.index = 4'(idx_of[g]);
      sb.push_back(e);
      n[g]++;
      last = g;
      @(posedge clock);
    end
    #1;
    request_valid = 2'b00;
    drain();
    check("rr_count_req0", 32'(n[0]), 32'd10);
    check("rr_count_req1", 32'(n[1]), 32'd10);
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 10; j++) do_release(4'(idx_of[r]), (j == 9));
    end

    // Fill all 16 entries, then a 17th tag must stall until an entry is evicted.
    for (int i = 0; i < 16; i++) do_request(0, 8'h40 + 8'(i), 4'(i), 1'b0);
    @(negedge clock);
    check("dir_full_after_fill", 32'(dir_full), 32'd1);
    @(posedge clock); #1;
    request_tag[15:8] = 8'h80;
    request_valid     = 2'b10;
    wait_ready(1, ok);
    e.requester = 1'b1;
    e.index     = 4'd7;
    e.hit       = 1'b0;
    if (ok) sb.push_back(e);
    @(posedge clock); #1;
    request_tag[7:0] = 8'h90;
    request_valid    = 2'b01;
    repeat (3) @(negedge clock);
    check("stall_ready_low", 32'(request_ready), 32'd0);
    check("stall_no_response", 32'(response_valid), 32'd0);
    check("stall_search_tag", 32'(dir_search_tag), 32'h80);
    check("stall_no_allocate", 32'(dir_allocate_enable), 32'd0);
    @(posedge clock); #1;
    request_valid = 2'b00;
    release_valid = 1'b1;
    release_index = 4'd7;
    @(negedge clock);
    check("stall_evict", 32'(dir_evict_enable), 32'd1);
    check("evict_frees_next_cycle", 32'(dir_allocate_enable), 32'd0);
    @(posedge clock); #1;
    release_valid = 1'b0;
    @(negedge clock);
    check("stall_allocate", 32'(dir_allocate_enable), 32'd1);
    check("stall_allocate_tag", 32'(dir_allocate_tag), 32'h80);
    drain();

    // Release and hit on index 5 in the same cycle: count stays 1.
    @(posedge clock); #1;
    request_tag[7:0] = 8'h45;
    request_valid    = 2'b01;
    wait_ready(0, ok);
    e.requester = 1'b0;
    e.index     = 4'd5;
    e.hit       = 1'b1;
    if (ok) sb.push_back(e);
    @(posedge clock); #1;
    request_valid = 2'b00;
    release_valid = 1'b1;
    release_index = 4'd5;
    @(negedge clock);
    check("same_cycle_no_evict", 32'(dir_evict_enable), 32'd0);
    @(posedge clock); #1;
    release_valid = 1'b0;
    drain();
    do_release(4'd5, 1'b1);

    // Reset while holding a response.
    @(posedge clock); #1;
    response_ready   = 1'b0;
    request_tag[7:0] = 8'h46;
    request_valid    = 2'b01;
    wait_ready(0, ok);
    @(posedge clock); #1;
    request_valid = 2'b00;
    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while (!response_valid && w < 10);
    check("respond_held", 32'(response_valid), 32'd1);
    @(posedge clock); #1;
    reset     = 1'b1;
    dir_reset = 1'b1;
    sb.delete();
    @(posedge clock);
    @(negedge clock);
    check("reset_in_respond_valid", 32'(response_valid), 32'd0);
    check("reset_in_respond_index", 32'(response_index), 32'd0);
    #1;
    @(posedge clock); #1;
    reset          = 1'b0;
    dir_reset      = 1'b0;
    response_ready = 1'b1;
    @(negedge clock);
    check("reset_dir_empty", 32'(dir_empty), 32'd1);
    do_release(4'd6, 1'b0);
    do_release(4'd4, 1'b0);
    do_request(1, 8'h3C, 4'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
